timer_counter: RTL and testbench
================================

# timer_counter

Memory-mapped down-counting timer that sits directly behind the system bridge as the device at 0x7f00 (instance 1) or 0x7f10 (instance 2). The bridge drives its write enable, word address and write data, and consumes its read data and interrupt request. Two modes are supported: one-shot with a held interrupt, and auto-reload with a one-cycle interrupt pulse per period.

## Interface
- No parameters; the base address is decoded by the bridge.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `addr`  in  30  word address `[31:2]` from the bridge; only `addr[3:2]` is decoded.
- `we`  in  1  full-word write strobe (bridge enable for this instance).
- `din`  in  32  write data.
- `dout`  out  32  combinational read data.
- `irq`  out  1  interrupt request, equal to `CTRL.IM & irq_flag`.

## Operation
- Register map by `addr[3:2]`:
  - 0: CTRL, read/write.
  - 1: PRESET, read/write.
  - 2: COUNT, read-only; writes are ignored.
  - 3: reads 0; writes are ignored.
- CTRL fields:
  - `[0]` EN.
  - `[2:1]` MODE: 00 = one-shot; 01 = auto-reload; 10 and 11 behave as 00.
  - `[3]` IM, interrupt mask.
  - `[31:4]` read as 0 and are not stored.
- Any write (`we=1`) to CTRL or PRESET clears `irq_flag`.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: if EN, go to LOAD; otherwise stay.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT:
    - If !EN, go to IDLE and hold COUNT.
    - Else if COUNT > 1, COUNT <= COUNT-1.
    - Else COUNT <= 0, `irq_flag` <= 1, go to INT.
  - INT, MODE 00: CTRL.EN <= 0, go to IDLE; `irq_flag` stays set.
  - INT, MODE 01: `irq_flag` <= 0, go to LOAD.
- Simultaneous events:
  - A CTRL write in the same cycle as the INT auto-clear of EN: the written value wins.
  - A CTRL write in the same cycle as a flag set (entering INT): the clear wins.
  - A PRESET write during CNT does not affect COUNT until the next LOAD.
  - Clearing EN during LOAD still loads COUNT; the FSM reaches IDLE from CNT on the following edge.
- COUNT is 32-bit unsigned. There is no wrap-around: COUNT never decrements below 0.

## Timing
- Reset values (asserted asynchronously): state IDLE, CTRL = 0, PRESET = 0, COUNT = 0, `irq_flag` = 0, `irq` = 0, `dout` = 0 for every address.
- Register writes take effect at the rising edge where `we=1`.
- `dout` is purely combinational from the current registers and `addr`, so read data is valid in the same cycle as the address.
- After the enabling CTRL write edge, with PRESET = N:
  - LOAD is reached 1 edge later.
  - CNT, with COUNT = N, is reached 2 edges later.
  - INT is reached max(N,1)+2 edges later; `irq` rises then if IM = 1.
- MODE 00: `irq` stays high until any write to CTRL or PRESET.
- MODE 01: `irq` is high for exactly 1 cycle per period. The period is max(N,1)+2 cycles (INT, LOAD, then max(N,1) CNT cycles).
- IM = 0 masks only `irq`; `irq_flag` still sets, and setting IM later raises `irq` immediately if the flag is still set.
- Reset asserted mid-count returns everything to the reset values immediately, with no interrupt emitted.

## Test plan
- Reset and readback:
  - Stimulus: hold `reset` = 0, release it, then read addresses 0/1/2/3.
  - Required: all reads return 0, `irq` = 0.
  - Stimulus: write CTRL = 0xFFFFFFFF, then read CTRL.
  - Required: read returns 0x0000000F.
- One-shot:
  - Stimulus: PRESET = 3, then CTRL = 0x9 (EN, MODE 00, IM).
  - Required: COUNT reads 3, 2, 1, 0 on successive cycles starting 2 edges after the CTRL write.
  - Required: `irq` rises 5 edges after the CTRL write and stays high; CTRL reads 0x8 afterwards.
  - Stimulus: write PRESET.
  - Required: `irq` drops at that edge.
- Auto-reload:
  - Stimulus: PRESET = 2, CTRL = 0xB (EN, MODE 01, IM).
  - Required: `irq` is a 1-cycle pulse every 4 cycles, for at least 3 periods.
  - Stimulus: write CTRL = 0.
  - Required: counting stops; COUNT holds; no further pulses.
- Zero preset and masking:
  - Stimulus: PRESET = 0, CTRL = 0x1 (IM = 0).
  - Required: INT is reached 3 edges after the write; `irq` stays 0.
  - Stimulus: write PRESET = 5.
  - Required: `irq_flag` clears, and `irq` stays 0 when IM is then set alone (e.g. CTRL = 0x8).
- Collisions and ignored writes:
  - Stimulus: write COUNT = 0x1234 during CNT.
  - Required: COUNT is unaffected.
  - Stimulus: in the MODE 00 INT cycle, write CTRL = 0x9.
  - Required: EN remains 1, the FSM reloads, and `irq_flag` is clear.
- Asynchronous reset:
  - Stimulus: assert `reset` between clock edges while COUNT = 7 in CNT.
  - Required: COUNT, CTRL, `irq` and state clear immediately, with no clock edge needed.

Source files
------------

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with one-shot and auto-reload modes.
// Registers: CTRL (EN, MODE, IM), PRESET, COUNT (read-only); irq = IM & irq_flag.
module timer_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_e;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] MODE_RELOAD = 2'b01;

  state_e      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_flag_q, irq_flag_d;

  logic        ctrl_en;
  logic        ctrl_im;
  logic [1:0]  ctrl_mode;
  logic        unused_addr;

  assign ctrl_en     = ctrl_q[0];
  assign ctrl_mode   = ctrl_q[2:1];
  assign ctrl_im     = ctrl_q[3];
  assign unused_addr = ^addr[31:4];

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;

    unique case (state_q)
      S_IDLE: begin
        if (ctrl_en) state_d = S_LOAD;
      end
      S_LOAD: begin
        count_d = preset_q;
        state_d = S_CNT;
      end
      S_CNT: begin
        if (!ctrl_en) begin
          state_d = S_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d    = '0;
          irq_flag_d = 1'b1;
          state_d    = S_INT;
        end
      end
      S_INT: begin
        if (ctrl_mode == MODE_RELOAD) begin
          irq_flag_d = 1'b0;
          state_d    = S_LOAD;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Bus writes come last so they override the FSM's EN auto-clear and flag set.
    if (we) begin
      if (addr[3:2] == ADDR_CTRL) begin
        ctrl_d     = din[3:0];
        irq_flag_d = 1'b0;
      end else if (addr[3:2] == ADDR_PRESET) begin
        preset_d   = din;
        irq_flag_d = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  always_comb begin
    dout = '0;
    unique case (addr[3:2])
      ADDR_CTRL:   dout = {28'd0, ctrl_q};
      ADDR_PRESET: dout = preset_q;
      ADDR_COUNT:  dout = count_q;
      default:     dout = '0;
    endcase
  end

  assign irq = ctrl_im & irq_flag_q;

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: expectations are queued as stimulus is
// driven and compared against reads of dout/irq once the cycle settles.
module tb_timer_counter;

  localparam int SEL_CTRL   = 0;
  localparam int SEL_PRESET = 1;
  localparam int SEL_COUNT  = 2;
  localparam int SEL_RSVD   = 3;
  localparam int SEL_IRQ    = 4;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } sb_entry_t;

  logic        clk;
  logic        reset;
  logic [31:2] addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  sb_entry_t sb_q[$];
  int        n_checks = 0;
  int        n_errors = 0;

  timer_counter dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .we   (we),
    .din  (din),
    .dout (dout),
    .irq  (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input int sel, input logic [31:0] exp, input string tag);
    sb_entry_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  // Pops every pending expectation and compares it with the current DUT output.
  task automatic observe_all();
    sb_entry_t   e;
    logic [31:0] got;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.sel == SEL_IRQ) begin
        got = {31'd0, irq};
      end else begin
        addr = {28'd0, e.sel[1:0]};
        #1;
        got = dout;
      end
      check(e.tag, got, e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = {28'd0, a};
    din  = d;
    we   = 1'b1;
    tick();
    we   = 1'b0;
  endtask

  function automatic logic [31:0] reload_count(input int k);
    if (k < 2) return 32'd0;
    case ((k - 2) % 4)
      0:       return 32'd2;
      1:       return 32'd1;
      default: return 32'd0;
    endcase
  endfunction

  initial begin
    reset = 1'b0;
    we    = 1'b0;
    addr  = '0;
    din   = '0;

    // Reset state and readback
    #12;
    sb_push(SEL_CTRL, 32'd0, "rst_ctrl");
    sb_push(SEL_PRESET, 32'd0, "rst_preset");
    sb_push(SEL_COUNT, 32'd0, "rst_count");
    sb_push(SEL_IRQ, 32'd0, "rst_irq");
    observe_all();
    @(negedge clk);
    reset = 1'b1;
    tick();
    for (int a = 0; a < 4; a++) sb_push(a, 32'd0, $sformatf("post_rst_rd%0d", a));
    sb_push(SEL_IRQ, 32'd0, "post_rst_irq");
    observe_all();

    wr(2'd0, 32'hFFFF_FFFF);
    sb_push(SEL_CTRL, 32'h0000_000F, "ctrl_mask");
    observe_all();
    wr(2'd0, 32'd0);
    tick();
    tick();
    sb_push(SEL_COUNT, 32'd0, "ctrl_ff_count");
    sb_push(SEL_IRQ, 32'd0, "ctrl_ff_irq");
    observe_all();

    // One-shot, PRESET = 3
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h9);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      if (k < 6) sb_push(SEL_COUNT, (k < 2) ? 32'd0 : 32'(5 - k), $sformatf("os_count_e%0d", k));
      sb_push(SEL_IRQ, (k >= 5) ? 32'd1 : 32'd0, $sformatf("os_irq_e%0d", k));
      if (k >= 6) sb_push(SEL_CTRL, 32'h8, $sformatf("os_ctrl_e%0d", k));
      observe_all();
    end
    wr(2'd1, 32'd7);
    sb_push(SEL_IRQ, 32'd0, "os_irq_clr");
    observe_all();

    // Auto-reload, PRESET = 2: period 4
    wr(2'd1, 32'd2);
    wr(2'd0, 32'hB);
    for (int k = 0; k < 19; k++) begin
      if (k > 0) tick();
      sb_push(SEL_COUNT, reload_count(k), $sformatf("ar_count_e%0d", k));
      sb_push(SEL_IRQ, (k >= 4 && k % 4 == 0) ? 32'd1 : 32'd0, $sformatf("ar_irq_e%0d", k));
      observe_all();
    end
    wr(2'd0, 32'd0);
    for (int j = 0; j < 8; j++) begin
      if (j > 0) tick();
      sb_push(SEL_COUNT, 32'd1, $sformatf("ar_hold_count%0d", j));
      sb_push(SEL_IRQ, 32'd0, $sformatf("ar_hold_irq%0d", j));
      observe_all();
    end

    // Zero preset with IM = 0
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h1);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      sb_push(SEL_CTRL, (k < 4) ? 32'h1 : 32'h0, $sformatf("zp_ctrl_e%0d", k));
      sb_push(SEL_COUNT, (k < 2) ? 32'd1 : 32'd0, $sformatf("zp_count_e%0d", k));
      sb_push(SEL_IRQ, 32'd0, $sformatf("zp_irq_e%0d", k));
      observe_all();
    end
    wr(2'd1, 32'd5);
    sb_push(SEL_PRESET, 32'd5, "zp_preset");
    sb_push(SEL_IRQ, 32'd0, "zp_irq_after_preset");
    observe_all();
    wr(2'd0, 32'h8);
    sb_push(SEL_CTRL, 32'h8, "zp_ctrl_im");
    sb_push(SEL_IRQ, 32'd0, "zp_irq_im");
    observe_all();
    tick();
    sb_push(SEL_IRQ, 32'd0, "zp_irq_im_late");
    observe_all();

    // Collisions: COUNT write ignored, PRESET write deferred, CTRL write in INT wins
    wr(2'd1, 32'd6);
    wr(2'd0, 32'h9);
    tick();
    tick();
    sb_push(SEL_COUNT, 32'd6, "col_count_e2");
    observe_all();
    wr(2'd2, 32'h1234);
    sb_push(SEL_COUNT, 32'd5, "col_count_wr");
    observe_all();
    for (int k = 4; k <= 8; k++) begin
      if (k == 5) wr(2'd1, 32'd9);
      else tick();
      sb_push(SEL_COUNT, 32'(8 - k), $sformatf("col_count_e%0d", k));
      sb_push(SEL_IRQ, (k == 8) ? 32'd1 : 32'd0, $sformatf("col_irq_e%0d", k));
      observe_all();
    end
    wr(2'd0, 32'h9);
    sb_push(SEL_CTRL, 32'h9, "col_ctrl_int");
    sb_push(SEL_IRQ, 32'd0, "col_irq_int");
    observe_all();
    tick();
    tick();
    sb_push(SEL_COUNT, 32'd9, "col_reload");
    sb_push(SEL_IRQ, 32'd0, "col_reload_irq");
    observe_all();

    // Asynchronous reset mid-count
    tick();
    tick();
    sb_push(SEL_COUNT, 32'd7, "ar_pre_count");
    observe_all();
    #1;
    reset = 1'b0;
    #1;
    sb_push(SEL_COUNT, 32'd0, "async_count");
    sb_push(SEL_CTRL, 32'd0, "async_ctrl");
    sb_push(SEL_PRESET, 32'd0, "async_preset");
    sb_push(SEL_IRQ, 32'd0, "async_irq");
    observe_all();
    @(negedge clk);
    reset = 1'b1;
    tick();
    tick();
    sb_push(SEL_COUNT, 32'd0, "post_async_count");
    sb_push(SEL_IRQ, 32'd0, "post_async_irq");
    sb_push(SEL_RSVD, 32'd0, "post_async_rsvd");
    observe_all();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
